// File: rtl/ifu_prefetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch buffer.
package ifu_prefetch_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [INST_W-1:0] INST_NOP       = 32'h0000_0001;
    localparam logic [INST_W-1:0] ZERO_WORD      = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] CPU_RESET_ADDR = 32'h0000_0000;

    // One buffered fetch: address in the upper half, instruction word in the lower half.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Force an address onto a word boundary.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO holding fetched {addr, inst} entries; flush wins over push.
module ifu_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (!do_push && do_pop)
                count <= count - CW'(1);
        end
    end

    // Entry storage; contents are don't-care until counted, so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: sequential PC generation on a pipelined req/gnt/rvalid bus,
// a small prefetch buffer toward decode, and redirect handling that drops in-flight words.
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = CPU_RESET_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ready_i
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW:0]   in_flight;
    logic          handshake;
    logic          push;
    logic          pop;
    logic [31:0]   jump_target;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    // The cap counts buffered plus outstanding words; a same-cycle pop is not credited.
    assign in_flight   = {1'b0, fifo_count} + {1'b0, outstanding};
    assign ibus_req_o  = ~rst & ~jump_flag_i & (in_flight < {1'b0, DEPTH_C});
    assign ibus_addr_o = pc;
    assign handshake   = ibus_req_o & ibus_gnt_i;
    assign jump_target = word_align(jump_addr_i);

    // A response is kept only when nothing stale is pending and no redirect is under way.
    assign push       = ibus_rvalid_i & ~jump_flag_i & (discard == '0);
    assign pop        = inst_valid_o & inst_ready_i;
    assign push_entry = '{addr: resp_pc, inst: ibus_rdata_i};

    ifu_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (jump_flag_i),
        .data_in (push_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .head    (head_entry)
    );

    assign inst_valid_o = ~fifo_empty;
    assign inst_o       = inst_valid_o ? head_entry.inst : INST_NOP;
    assign inst_addr_o  = inst_valid_o ? head_entry.addr : ZERO_WORD;

    // Request PC: reload on redirect, advance one word per accepted request.
    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else if (jump_flag_i)
            pc <= jump_target;
        else if (handshake)
            pc <= pc + 32'd4;
    end

    // Address of the next kept response; since the bus returns in order it trails pc.
    always_ff @(posedge clk) begin
        if (rst)
            resp_pc <= RESET_PC;
        else if (jump_flag_i)
            resp_pc <= jump_target;
        else if (push)
            resp_pc <= resp_pc + 32'd4;
    end

    // Granted-but-unreturned count; a redirect does not cancel words already on the bus.
    always_ff @(posedge clk) begin
        if (rst)
            outstanding <= '0;
        else if (handshake && !ibus_rvalid_i)
            outstanding <= outstanding + CW'(1);
        else if (!handshake && ibus_rvalid_i)
            outstanding <= outstanding - CW'(1);
    end

    // Stale-response counter: armed from outstanding on redirect, drained by each dropped word.
    always_ff @(posedge clk) begin
        if (rst)
            discard <= '0;
        else if (jump_flag_i)
            discard <= outstanding - CW'(ibus_rvalid_i);
        else if (ibus_rvalid_i && discard != '0)
            discard <= discard - CW'(1);
    end

    a_count_cap: assert property (@(posedge clk) disable iff (rst) fifo_count <= DEPTH_C);
    a_out_cap:   assert property (@(posedge clk) disable iff (rst) outstanding <= DEPTH_C);
    a_discard:   assert property (@(posedge clk) disable iff (rst) discard <= outstanding);
    a_no_ovf:    assert property (@(posedge clk) disable iff (rst) push |-> (!fifo_full || pop));
    a_aligned:   assert property (@(posedge clk) disable iff (rst) ibus_addr_o[1:0] == 2'b00);

endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomized bench for ifu_prefetch: a bus slave with variable latency and a
// spec-level model (buffer of fetched addresses, pending discard count, stream order).
module tb_ifu_prefetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_ready_i;

    always #5 clk = ~clk;

    ifu_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_flag_i   (jump_flag_i),
        .jump_addr_i   (jump_addr_i),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_gnt_i    (ibus_gnt_i),
        .ibus_rvalid_i (ibus_rvalid_i),
        .ibus_rdata_i  (ibus_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o),
        .inst_ready_i  (inst_ready_i)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    rsp_t        slave[$];
    logic [31:0] m_buf[$];
    int          m_disc;
    logic [31:0] m_pc;
    logic [31:0] exp_stream;
    int          cyc;

    int gnt_pct, rdy_pct, lat_min, lat_max;
    int checks, errors;

    logic [97:0] obs_vec, exp_vec;
    bit          popped;
    logic [31:0] pop_addr, pop_exp;

    // Memory contents seen by the bus: a scrambled function of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_reset();
        slave.delete();
        m_buf.delete();
        m_disc     = 0;
        m_pc       = RESET_PC;
        exp_stream = RESET_PC;
        cyc        = 0;
    endtask

    task automatic drive_idle();
        ibus_gnt_i    = 1'b0;
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i  = 32'h0;
        inst_ready_i  = 1'b0;
        jump_flag_i   = 1'b0;
        jump_addr_i   = 32'h0;
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One bus/decode cycle: drive inputs, sample outputs, form expectations, advance model.
    task automatic cycle(input bit jmp, input logic [31:0] tgt);
        bit ev, er, rv;
        int lat;
        @(negedge clk);
        ibus_gnt_i   = ($urandom_range(0, 99) < gnt_pct);
        inst_ready_i = ($urandom_range(0, 99) < rdy_pct);
        jump_flag_i  = jmp;
        jump_addr_i  = tgt;
        rv = (slave.size() > 0) && (slave[0].due <= cyc);
        ibus_rvalid_i = rv;
        ibus_rdata_i  = rv ? memf(slave[0].addr) : $urandom;
        #1;
        er = !jmp && ((m_buf.size() + slave.size()) < DEPTH);
        ev = (m_buf.size() != 0);
        exp_vec = {er, er ? m_pc : 32'h0, ev, ev ? m_buf[0] : 32'h0, ev ? memf(m_buf[0]) : NOP};
        obs_vec = {ibus_req_o, ibus_req_o ? ibus_addr_o : 32'h0, inst_valid_o, inst_addr_o, inst_o};
        popped   = inst_valid_o && inst_ready_i;
        pop_addr = inst_addr_o;
        pop_exp  = exp_stream;
        if (popped) begin
            exp_stream = exp_stream + 32'd4;
            if (m_buf.size() > 0) m_buf.delete(0);
        end
        if (jmp) begin
            m_disc = slave.size() - (rv ? 1 : 0);
            m_buf.delete();
        end else if (rv) begin
            if (m_disc > 0) m_disc--;
            else m_buf.push_back(slave[0].addr);
        end
        if (rv) slave.delete(0);
        if (ibus_req_o && ibus_gnt_i) begin
            lat = $urandom_range(lat_min, lat_max);
            slave.push_back('{ibus_addr_o, cyc + lat});
            m_pc = m_pc + 32'd4;
        end
        if (jmp) begin
            m_pc       = {tgt[31:2], 2'b00};
            exp_stream = m_pc;
        end
        cyc++;
    endtask

    task automatic test_reset();
        gnt_pct = 100; rdy_pct = 0; lat_min = 1; lat_max = 1;
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({ibus_req_o, inst_valid_o, inst_o, inst_addr_o} !== {1'b0, 1'b0, NOP, 32'h0}) begin
                errors++;
                $display("FAIL reset_hold act=%h req=%h", {ibus_req_o, inst_valid_o, inst_o, inst_addr_o},
                         {1'b0, 1'b0, NOP, 32'h0});
            end
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({ibus_req_o, ibus_addr_o, inst_valid_o, inst_o, inst_addr_o} !== {1'b1, RESET_PC, 1'b0, NOP, 32'h0}) begin
            errors++;
            $display("FAIL reset_release act=%h req=%h", {ibus_req_o, ibus_addr_o, inst_valid_o, inst_o, inst_addr_o},
                     {1'b1, RESET_PC, 1'b0, NOP, 32'h0});
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'h0);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL reset_first_fetch cyc=%0d act=%h req=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_stream();
        int pops = 0;
        apply_reset(2);
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 32'h0);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL stream cyc=%0d act=%h req=%h", cyc, obs_vec, exp_vec);
            end
            if (popped) begin
                pops++;
                checks++;
                if (pop_addr !== pop_exp) begin
                    errors++;
                    $display("FAIL stream_order act=%h req=%h", pop_addr, pop_exp);
                end
            end
        end
        checks++;
        if (pops < 13) begin
            errors++;
            $display("FAIL stream_rate act=%0d req>=13", pops);
        end
    endtask

    task automatic test_backpressure();
        apply_reset(2);
        gnt_pct = 100; rdy_pct = 0; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 32'h0);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d act=%h req=%h", cyc, obs_vec, exp_vec);
            end
        end
        checks++;
        if ({ibus_req_o, inst_valid_o, m_buf.size()} !== {1'b0, 1'b1, 32'd2}) begin
            errors++;
            $display("FAIL bp_full act=req%b/valid%b/buf%0d req=req0/valid1/buf2", ibus_req_o, inst_valid_o, m_buf.size());
        end
        rdy_pct = 100;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 32'h0);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL bp_release cyc=%0d act=%h req=%h", cyc, obs_vec, exp_vec);
            end
            if (popped) begin
                checks++;
                if (pop_addr !== pop_exp) begin
                    errors++;
                    $display("FAIL bp_order act=%h req=%h", pop_addr, pop_exp);
                end
            end
        end
    endtask

    task automatic test_redirect();
        int  n;
        bit  seen = 0;
        apply_reset(2);
        gnt_pct = 100; rdy_pct = 100; lat_min = 3; lat_max = 3;
        n = 0;
        while (slave.size() < 2 && n < 10) begin
            cycle(1'b0, 32'h0);
            n++;
        end
        checks++;
        if (slave.size() != 2) begin
            errors++;
            $display("FAIL redirect_setup act=%0d req=2", slave.size());
        end
        cycle(1'b1, 32'h0000_0105);
        checks++;
        if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL redirect_cycle act=%h req=%h", obs_vec, exp_vec);
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle(1'b0, 32'h0);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL redirect_after cyc=%0d act=%h req=%h", cyc, obs_vec, exp_vec);
            end
            if (popped) begin
                seen = 1;
                checks++;
                if ({pop_addr, inst_o} !== {32'h0000_0104, memf(32'h0000_0104)}) begin
                    errors++;
                    $display("FAIL redirect_target act=%h req=%h", {pop_addr, inst_o}, {32'h0000_0104, memf(32'h0000_0104)});
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL redirect_timeout act=none req=instr@00000104");
        end
    endtask

    task automatic test_redirect_same_cycle();
        int n;
        bit seen = 0;
        apply_reset(2);
        gnt_pct = 100; rdy_pct = 100; lat_min = 2; lat_max = 2;
        n = 0;
        while (!((slave.size() > 0) && (slave[0].due <= cyc) && (m_buf.size() > 0)) && n < 20) begin
            cycle(1'b0, 32'h0);
            n++;
        end
        cycle(1'b1, 32'h2000_0042);
        checks++;
        if ({ibus_rvalid_i, popped, obs_vec} !== {1'b1, 1'b1, exp_vec}) begin
            errors++;
            $display("FAIL jump_rvalid_pop act=%h req=%h", {ibus_rvalid_i, popped, obs_vec}, {1'b1, 1'b1, exp_vec});
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle(1'b0, 32'h0);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL jump_rvalid_after cyc=%0d act=%h req=%h", cyc, obs_vec, exp_vec);
            end
            if (popped) begin
                seen = 1;
                checks++;
                if (pop_addr !== 32'h2000_0040) begin
                    errors++;
                    $display("FAIL jump_rvalid_target act=%h req=20000040", pop_addr);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL jump_rvalid_timeout act=none req=instr@20000040");
        end
    endtask

    task automatic test_midop_reset();
        int n;
        apply_reset(2);
        gnt_pct = 100; rdy_pct = 0; lat_min = 3; lat_max = 3;
        n = 0;
        while (!(m_buf.size() >= 1 && slave.size() >= 1) && n < 20) begin
            cycle(1'b0, 32'h0);
            n++;
        end
        checks++;
        if (!(m_buf.size() >= 1 && slave.size() >= 1)) begin
            errors++;
            $display("FAIL midop_setup act=buf%0d/out%0d req=buf>=1/out>=1", m_buf.size(), slave.size());
        end
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        @(posedge clk);
        #1;
        checks++;
        if ({ibus_req_o, inst_valid_o, inst_o, inst_addr_o} !== {1'b0, 1'b0, NOP, 32'h0}) begin
            errors++;
            $display("FAIL midop_reset act=%h req=%h", {ibus_req_o, inst_valid_o, inst_o, inst_addr_o},
                     {1'b0, 1'b0, NOP, 32'h0});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({ibus_req_o, ibus_addr_o, inst_valid_o} !== {1'b1, RESET_PC, 1'b0}) begin
            errors++;
            $display("FAIL midop_refetch act=%h req=%h", {ibus_req_o, ibus_addr_o, inst_valid_o}, {1'b1, RESET_PC, 1'b0});
        end
        rdy_pct = 100; lat_min = 1; lat_max = 2;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 32'h0);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL midop_after cyc=%0d act=%h req=%h", cyc, obs_vec, exp_vec);
            end
            if (popped) begin
                checks++;
                if (pop_addr !== pop_exp) begin
                    errors++;
                    $display("FAIL midop_order act=%h req=%h", pop_addr, pop_exp);
                end
            end
        end
    endtask

    task automatic test_random();
        bit          j;
        logic [31:0] t;
        apply_reset(2);
        gnt_pct = 70; rdy_pct = 60; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 800; i++) begin
            j = ($urandom_range(0, 99) < 5);
            t = $urandom;
            cycle(j, t);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL random cyc=%0d act=%h req=%h", cyc, obs_vec, exp_vec);
            end
            if (popped) begin
                checks++;
                if (pop_addr !== pop_exp) begin
                    errors++;
                    $display("FAIL random_order cyc=%0d act=%h req=%h", cyc, pop_addr, pop_exp);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive_idle();
        model_reset();
        gnt_pct = 0; rdy_pct = 0; lat_min = 1; lat_max = 1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_same_cycle();
        test_midop_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
